// File: rtl/alu_uart_sequencer.sv
// Byte-stream sequencer for the 8-bit ALU: collects A, B and opcode from the
// UART receiver, then hands the ALU result to the transmitter.
module alu_uart_sequencer #(
    parameter int NB_DATA     = 8,
    parameter int NB_OPE      = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_dato_a,
    output logic [NB_DATA-1:0] o_alu_dato_b,
    output logic [NB_OPE-1:0]  o_alu_ope_sel,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_drop
);

    localparam int NB_CNT = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYC - 1);
    localparam logic [NB_CNT-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t            state;
    logic [NB_CNT-1:0] cnt;
    logic [NB_CNT-1:0] cnt_inc;
    logic              expire;

    // Saturating increment; expiry fires on the edge the count reaches its last value
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + NB_CNT'(1);
    assign expire  = (cnt_inc == CNT_LAST);
    assign o_busy  = (state == EXEC) || (state == WAIT_TX);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= WAIT_A;
            cnt           <= '0;
            o_alu_dato_a  <= '0;
            o_alu_dato_b  <= '0;
            o_alu_ope_sel <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_timeout     <= 1'b0;
            o_drop        <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_drop     <= 1'b0;
            unique case (state)
                WAIT_A: begin
                    cnt <= '0;
                    if (i_rx_done) begin
                        o_alu_dato_a <= i_rx_data;
                        state        <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_dato_b <= i_rx_data;
                        cnt          <= '0;
                        state        <= WAIT_OP;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_A;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_ope_sel <= i_rx_data[NB_OPE-1:0];
                        cnt           <= '0;
                        state         <= EXEC;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_A;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_drop     <= i_rx_done;
                    cnt        <= '0;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    o_drop <= i_rx_done;
                    // A done pulse overlapping the start pulse cannot belong to it
                    if (i_tx_done && !o_tx_start) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Randomized bench for alu_uart_sequencer with a frame-level reference model
// and a few directed frames whose results are worked out by hand.
module tb_alu_uart_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] dut_a, dut_b, tx_data;
    logic [5:0] dut_op;
    logic       tx_start, busy, timeout, drop;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_uart_sequencer #(.NB_DATA(8), .NB_OPE(6), .TIMEOUT_CYC(TO)) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .i_alu_result(alu_result),
        .o_alu_dato_a(dut_a),
        .o_alu_dato_b(dut_b),
        .o_alu_ope_sel(dut_op),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done(tx_done),
        .o_busy(busy),
        .o_timeout(timeout),
        .o_drop(drop)
    );

    function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return 8'($signed(a) >>> b);
            6'h02: return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(dut_a, dut_b, dut_op);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as a byte count plus pending-result flags
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_to, m_drop, prev_start;
    int         nbytes, idle;
    bit         exec_due, in_tx;

    always @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            m_a = '0; m_b = '0; m_op = '0; m_tx = '0;
            m_start = 0; m_to = 0; m_drop = 0;
            nbytes = 0; idle = 0; exec_due = 0; in_tx = 0;
        end else begin
            prev_start = m_start;
            m_start = 0; m_to = 0; m_drop = 0;
            if (exec_due) begin
                m_tx = alu_ref(m_a, m_b, m_op);
                m_start = 1;
                exec_due = 0;
                in_tx = 1;
                m_drop = rx_done;
            end else if (in_tx) begin
                m_drop = rx_done;
                if (tx_done && !prev_start) in_tx = 0;
            end else if (rx_done) begin
                case (nbytes)
                    0: m_a = rx_data;
                    1: m_b = rx_data;
                    default: m_op = rx_data[5:0];
                endcase
                idle = 0;
                if (nbytes == 2) begin
                    nbytes = 0;
                    exec_due = 1;
                end else begin
                    nbytes++;
                end
            end else if (nbytes != 0) begin
                idle++;
                if (idle == TO - 1) begin
                    m_to = 1;
                    nbytes = 0;
                    idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp alu_a", dut_a, m_a);
        chk("cmp alu_b", dut_b, m_b);
        chk("cmp ope_sel", dut_op, m_op);
        chk("cmp tx_data", tx_data, m_tx);
        chk("cmp tx_start", tx_start, m_start);
        chk("cmp busy", busy, exec_due || in_tx);
        chk("cmp timeout", timeout, m_to);
        chk("cmp drop", drop, m_drop);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step(1);
        rx_done = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    task automatic frame(string name, logic [7:0] a, logic [7:0] b, logic [7:0] op, logic [7:0] exp);
        send(a);
        send(b);
        send(op);
        chk({name, " exec no start"}, tx_start, 0);
        step(1);
        chk({name, " start"}, tx_start, 1);
        chk({name, " result"}, tx_data, exp);
        step(1);
        chk({name, " start one cycle"}, tx_start, 0);
        done_pulse();
        chk({name, " idle after done"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [9];
        int k;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h3F};

        step(2);
        chk("reset tx_data", tx_data, 0);
        chk("reset busy", busy, 0);
        chk("reset alu_a", dut_a, 0);
        i_reset = 1'b1;
        step(1);

        send(8'h05);
        send(8'h03);
        send(8'h20);
        chk("t1 busy exec", busy, 1);
        chk("t1 alu_a", dut_a, 8'h05);
        chk("t1 alu_b", dut_b, 8'h03);
        chk("t1 ope_sel", dut_op, 6'h20);
        step(1);
        chk("t1 start", tx_start, 1);
        chk("t1 result", tx_data, 8'h08);
        step(1);
        done_pulse();
        chk("t1 idle", busy, 0);

        frame("sra", 8'hF0, 8'h02, 8'h03, 8'hFC);
        frame("srl", 8'h80, 8'h01, 8'h02, 8'h40);
        frame("add wrap", 8'h7F, 8'h01, 8'h20, 8'h80);

        send(8'h11);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (timeout) begin
                k = i;
                break;
            end
        end
        chk("timeout latency", k, 15);
        chk("timeout keeps a", dut_a, 8'h11);
        frame("after timeout", 8'h01, 8'h01, 8'h24, 8'h01);

        send(8'h0A);
        send(8'h0B);
        send(8'h22);
        step(2);
        send(8'h99);
        chk("drop pulse", drop, 1);
        chk("drop busy", busy, 1);
        step(1);
        chk("drop one cycle", drop, 0);
        done_pulse();
        frame("after drop", 8'h0C, 8'h0A, 8'h26, 8'h06);

        frame("invalid op", 8'hAA, 8'h55, 8'h3F, 8'h00);

        send(8'h21);
        send(8'h22);
        send(8'h25);
        step(2);
        #1 i_reset = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst tx_data", tx_data, 0);
        chk("async rst alu_a", dut_a, 0);
        chk("async rst ope", dut_op, 0);
        @(posedge clk);
        #2 i_reset = 1'b1;
        step(6);
        chk("no start after rst", tx_start, 0);

        send(8'h30);
        step(TO - 2);
        send(8'h04);
        chk("edge rx no timeout", timeout, 0);
        send(8'h20);
        step(1);
        chk("edge rx result", tx_data, 8'h34);
        step(1);
        done_pulse();

        for (int f = 0; f < 60; f++) begin
            for (int j = 0; j < 3; j++) begin
                step(($urandom % 12 == 0) ? 17 : $urandom_range(0, 3));
                send(j == 2 ? ops[$urandom % 9] : 8'($urandom));
            end
            step($urandom_range(0, 3));
            if ($urandom % 3 == 0) send(8'($urandom));
            step($urandom_range(1, 4));
            done_pulse();
            step(1);
        end

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
